// File: rtl/seg_scan_ctrl.sv
// Seven-segment multiplex scanner: rotating one-hot anode drive, digit select,
// per-digit blanking, 16-step PWM brightness and a frame-start pulse.
module seg_scan_ctrl #(
    parameter int DIGITS        = 4,
    parameter int PRESCALE      = 50000,
    parameter bit AN_ACTIVE_LOW = 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      enable,
    input  logic [DIGITS-1:0]         digit_en,
    input  logic [3:0]                brightness,
    output logic [DIGITS-1:0]         AN,
    output logic [$clog2(DIGITS)-1:0] sel,
    output logic                      frame_tick
);

    localparam int SUB_N = PRESCALE / 16;
    localparam int SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
    localparam int SEL_W = $clog2(DIGITS);
    localparam logic [SUB_W-1:0]  SUB_LOAD = SUB_W'(SUB_N - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{AN_ACTIVE_LOW}};

    logic              r_run;
    logic [SUB_W-1:0]  r_sub;
    logic [3:0]        r_phase;
    logic [SEL_W-1:0]  r_sel;
    logic [DIGITS-1:0] r_an;
    logic              r_frame_tick;

    logic              w_sub_tc;
    logic              w_slot_end;
    logic              w_wrap;
    logic [SUB_W-1:0]  w_sub_nxt;
    logic [3:0]        w_phase_nxt;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [DIGITS-1:0] w_an_nxt;

    // r_run holds the position on the first edge after reset so slot 0 gets its full length.
    always_comb begin
        w_sub_tc    = (r_sub == '0);
        w_slot_end  = r_run && w_sub_tc && (r_phase == 4'd15);
        w_wrap      = w_slot_end && (r_sel == SEL_LAST);
        w_sub_nxt   = r_sub;
        w_phase_nxt = r_phase;
        w_sel_nxt   = r_sel;
        if (r_run) begin
            if (w_sub_tc) begin
                w_sub_nxt   = SUB_LOAD;
                w_phase_nxt = r_phase + 4'd1;
            end else begin
                w_sub_nxt = r_sub - SUB_W'(1);
            end
            if (w_slot_end) begin
                w_sel_nxt = w_wrap ? '0 : r_sel + SEL_W'(1);
            end
        end
    end

    // Anode decode uses next-state position so AN and sel always move on the same edge.
    always_comb begin
        w_an_nxt = AN_IDLE;
        for (int i = 0; i < DIGITS; i++) begin
            w_an_nxt[i] = ((w_sel_nxt == SEL_W'(i)) && enable && digit_en[i] &&
                           (w_phase_nxt <= brightness)) ^ AN_ACTIVE_LOW;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_run        <= 1'b0;
            r_sub        <= SUB_LOAD;
            r_phase      <= 4'd0;
            r_sel        <= '0;
            r_an         <= AN_IDLE;
            r_frame_tick <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_sub        <= w_sub_nxt;
            r_phase      <= w_phase_nxt;
            r_sel        <= w_sel_nxt;
            r_an         <= w_an_nxt;
            r_frame_tick <= w_wrap;
        end
    end

    assign AN         = r_an;
    assign sel        = r_sel;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a 4-digit/32-cycle instance and an
// 8-digit/16-cycle instance checked cycle by cycle against a slot/phase model.
module tb_seg_scan_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst_a, en_a;
    logic [3:0] den_a, br_a;
    logic [3:0] an_a;
    logic [1:0] sel_a;
    logic       ft_a;

    logic       rst_b, en_b;
    logic [7:0] den_b;
    logic [3:0] br_b;
    logic [7:0] an_b;
    logic [2:0] sel_b;
    logic       ft_b;

    int checks   = 0;
    int failures = 0;
    int p_a;
    int p_b;

    seg_scan_ctrl #(.DIGITS(4), .PRESCALE(32), .AN_ACTIVE_LOW(1)) u_dut_a (
        .Clk(Clk), .Reset(rst_a), .enable(en_a), .digit_en(den_a),
        .brightness(br_a), .AN(an_a), .sel(sel_a), .frame_tick(ft_a)
    );

    seg_scan_ctrl #(.DIGITS(8), .PRESCALE(16), .AN_ACTIVE_LOW(1)) u_dut_b (
        .Clk(Clk), .Reset(rst_b), .enable(en_b), .digit_en(den_b),
        .brightness(br_b), .AN(an_b), .sel(sel_b), .frame_tick(ft_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected active-low anode word at position p (cycles since slot 0 start).
    function automatic logic [15:0] model_an(input int p, input int nd, input int ps,
                                             input logic en, input logic [15:0] den,
                                             input logic [3:0] br);
        int slot;
        int ph;
        logic [15:0] an;
        slot = (p / ps) % nd;
        ph   = (p % ps) / (ps / 16);
        an   = 16'hffff >> (16 - nd);
        if (en && den[slot] && (ph <= int'(br))) an[slot] = 1'b0;
        return an;
    endfunction

    task automatic run_a(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk); #1;
            p_a++;
            chk($sformatf("a_an p=%0d", p_a), {28'h0, an_a},
                {16'h0, model_an(p_a, 4, 32, en_a, {12'h0, den_a}, br_a)});
            chk($sformatf("a_sel p=%0d", p_a), {30'h0, sel_a}, 32'((p_a / 32) % 4));
            chk($sformatf("a_tick p=%0d", p_a), {31'h0, ft_a},
                {31'h0, (p_a % 128 == 0) && (p_a > 0)});
        end
    endtask

    task automatic run_b(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk); #1;
            p_b++;
            chk($sformatf("b_an p=%0d", p_b), {24'h0, an_b},
                {16'h0, model_an(p_b, 8, 16, en_b, {8'h0, den_b}, br_b)});
            chk($sformatf("b_sel p=%0d", p_b), {29'h0, sel_b}, 32'((p_b / 16) % 8));
            chk($sformatf("b_tick p=%0d", p_b), {31'h0, ft_b},
                {31'h0, (p_b % 128 == 0) && (p_b > 0)});
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; den_a = 4'hf;  br_a = 4'hf;
        rst_b = 1'b1; en_b = 1'b1; den_b = 8'hff; br_b = 4'hf;
        p_a = -1;
        p_b = -1;

        repeat (2) begin
            @(posedge Clk); #1;
            chk("a_rst_an",   {28'h0, an_a}, 32'h0000_000f);
            chk("a_rst_sel",  {30'h0, sel_a}, 32'h0);
            chk("a_rst_tick", {31'h0, ft_a}, 32'h0);
            chk("b_rst_an",   {24'h0, an_b}, 32'h0000_00ff);
        end

        // Plain scan through one full frame plus the wrap back to digit 0.
        rst_a = 1'b0;
        p_a   = -1;
        run_a(1);
        chk("a_first_an", {28'h0, an_a}, 32'h0000_000e);
        run_a(131);

        br_a = 4'd3;
        run_a(128);
        br_a = 4'd0;
        run_a(64);
        br_a = 4'd15;

        den_a = 4'b0101;
        run_a(128);
        den_a = 4'b0000;
        run_a(40);
        den_a = 4'hf;

        // Drop enable in the middle of slot 1, then restore it.
        while (p_a % 128 != 40) run_a(1);
        en_a = 1'b0;
        run_a(6);
        en_a = 1'b1;
        run_a(30);

        // One-cycle reset at slot 2, phase 7.
        while (p_a % 128 != 78) run_a(1);
        rst_a = 1'b1;
        @(posedge Clk); #1;
        chk("a_midrst_an",   {28'h0, an_a}, 32'h0000_000f);
        chk("a_midrst_sel",  {30'h0, sel_a}, 32'h0);
        chk("a_midrst_tick", {31'h0, ft_a}, 32'h0);
        rst_a = 1'b0;
        p_a   = -1;
        run_a(70);

        // Eight digits with one sub-count per phase.
        rst_b = 1'b0;
        p_b   = -1;
        run_b(1);
        chk("b_first_an", {24'h0, an_b}, 32'h0000_00fe);
        run_b(140);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
